// File: rtl/button_vote_decoder.sv
// Per-player Boyer-Moore majority vote over redundant button bytes carried in a
// UDP payload word stream; commits at packet end, clears everything on a packet drought.
module button_vote_decoder #(
    parameter int NUM_PLAYERS    = 2,
    parameter int BTN_W          = 8,
    parameter int CNT_W          = 8,
    parameter int MIN_VOTES      = 2,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         axiiv,
    input  logic [2*BTN_W-1:0]           axiid,
    output logic [NUM_PLAYERS*BTN_W-1:0] buttons,
    output logic                         buttons_valid,
    output logic [NUM_PLAYERS-1:0]       player_updated,
    output logic                         stale,
    output logic [15:0]                  packet_count,
    output logic [15:0]                  reject_count
);

    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_VOTES);

    logic                         r_prev_axiiv;
    logic [IDX_W-1:0]             r_idx;
    logic [BTN_W-1:0]             r_cand [NUM_PLAYERS];
    logic [CNT_W-1:0]             r_cnt  [NUM_PLAYERS];
    logic [WD_W-1:0]              r_wd;
    logic [NUM_PLAYERS*BTN_W-1:0] r_buttons;
    logic                         r_buttons_valid;
    logic [NUM_PLAYERS-1:0]       r_player_updated;
    logic                         r_stale;
    logic [15:0]                  r_packet_count;
    logic [15:0]                  r_reject_count;

    logic                         w_start;
    logic                         w_end;
    logic                         w_dup_ok;
    logic [BTN_W-1:0]             w_byte;
    logic                         w_expire;
    logic [NUM_PLAYERS-1:0]       w_commit;
    logic [BTN_W-1:0]             w_cand_nxt [NUM_PLAYERS];
    logic [CNT_W-1:0]             w_cnt_nxt  [NUM_PLAYERS];

    assign w_start  = axiiv & ~r_prev_axiiv;
    assign w_end    = ~axiiv & r_prev_axiiv;
    assign w_byte   = axiid[BTN_W-1:0];
    assign w_dup_ok = (axiid[2*BTN_W-1:BTN_W] == axiid[BTN_W-1:0]);
    // Packet end wins over a coincident expiry.
    assign w_expire = ~w_end && (r_wd == WD_LIMIT - 1'b1);

    // Vote state is zeroed on packet start so the first word votes against a clean slate.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            // NOTE: defaults first on every path keep this block purely combinational (no latches).
            w_cand_nxt[p] = w_start ? '0 : r_cand[p];
            w_cnt_nxt[p]  = w_start ? '0 : r_cnt[p];
            w_commit[p]   = (r_cnt[p] >= CNT_MIN);
            if (axiiv && w_dup_ok && (r_idx == IDX_W'(p))) begin
                if (w_cnt_nxt[p] == '0) begin
                    w_cand_nxt[p] = w_byte;
                    w_cnt_nxt[p]  = CNT_W'(1);
                end else if (w_byte == w_cand_nxt[p]) begin
                    if (w_cnt_nxt[p] != CNT_MAX) begin
                        w_cnt_nxt[p] = w_cnt_nxt[p] + 1'b1;
                    end
                end else begin
                    w_cnt_nxt[p] = w_cnt_nxt[p] - 1'b1;
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_axiiv     <= 1'b0;
            r_idx            <= '0;
            r_wd             <= '0;
            r_buttons        <= '0;
            r_buttons_valid  <= 1'b0;
            r_player_updated <= '0;
            r_stale          <= 1'b0;
            r_packet_count   <= '0;
            r_reject_count   <= '0;
            // NOTE: the vote arrays are tiny, so they are reset too rather than left to packet start.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_cand[p] <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            r_prev_axiiv <= axiiv;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_cand[p] <= w_cand_nxt[p];
                r_cnt[p]  <= w_cnt_nxt[p];
            end

            if (axiiv) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end

            if (axiiv && !w_dup_ok) begin
                r_reject_count <= r_reject_count + 1'b1;
            end

            r_buttons_valid  <= w_end;
            r_player_updated <= w_end ? w_commit : '0;

            if (w_end) begin
                r_wd           <= '0;
                r_packet_count <= r_packet_count + 1'b1;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (w_commit[p]) begin
                        r_buttons[p*BTN_W +: BTN_W] <= r_cand[p];
                    end
                end
                if (|w_commit) begin
                    r_stale <= 1'b0;
                end
            end else begin
                if (r_wd != WD_LIMIT) begin
                    r_wd <= r_wd + 1'b1;
                end
                if (w_expire) begin
                    r_buttons <= '0;
                    r_stale   <= 1'b1;
                end
            end
        end
    end

    assign buttons        = r_buttons;
    assign buttons_valid  = r_buttons_valid;
    assign player_updated = r_player_updated;
    assign stale          = r_stale;
    assign packet_count   = r_packet_count;
    assign reject_count   = r_reject_count;

endmodule
